// File: rtl/alien_swarm_pkg.sv
// Shared types and widths for the alien swarm controller.
package alien_swarm_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      MARCH   = 2'd0,
      DROP    = 2'd1,
      LANDED  = 2'd2,
      CLEARED = 2'd3
   } swarm_state_t;

   // Horizontal march direction.
   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_t;

   localparam int unsigned COORD_W = 11;  // screen coordinate width
   localparam int unsigned REL_W   = 12;  // coordinate difference width (MSB = borrow)
   localparam int unsigned CNT_W   = 8;   // alive counter / frame counter width
   localparam int unsigned IDX_W   = 4;   // row / column index width

   // Shift that turns a pixel offset into a cell index for a power-of-two pitch.
   function automatic int pitch_shift(input int pitch);
      return $clog2(pitch);
   endfunction

   localparam int DEF_SHIFT_X = pitch_shift(64);
   localparam int DEF_SHIFT_Y = pitch_shift(64);

endpackage

// File: rtl/alien_swarm_if.sv
// Pixel/bitmap/game-state bus around the alien swarm controller.
interface alien_swarm_if;
   import alien_swarm_pkg::*;

   logic               startOfFrame;
   logic               restart;
   logic [COORD_W-1:0] pixelX;
   logic [COORD_W-1:0] pixelY;
   logic               alienHit;
   logic [COORD_W-1:0] offsetX;
   logic [COORD_W-1:0] offsetY;
   logic               InsideRectangle;
   logic [COORD_W-1:0] swarmX;
   logic [COORD_W-1:0] swarmY;
   logic [CNT_W-1:0]   aliveCount;
   logic               allDead;
   logic               landed;

   modport master (
      output startOfFrame, restart, pixelX, pixelY, alienHit,
      input  offsetX, offsetY, InsideRectangle, swarmX, swarmY, aliveCount, allDead, landed
   );

   modport slave (
      input  startOfFrame, restart, pixelX, pixelY, alienHit,
      output offsetX, offsetY, InsideRectangle, swarmX, swarmY, aliveCount, allDead, landed
   );
endinterface

// File: rtl/alien_grid_decode.sv
// Registered pixel-to-cell decode plus a one-cycle hit pipe that lines the
// decoded cell up with the bitmap's (one register later) drawingRequest.
module alien_grid_decode
   import alien_swarm_pkg::*;
#(
   parameter int COLS    = 8,
   parameter int ROWS    = 4,
   parameter int PITCH_X = 64,
   parameter int PITCH_Y = 64,
   parameter int ALIEN_W = 52,
   parameter int ALIEN_H = 40
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 blank,
   input  logic [COORD_W-1:0]   pixel_x,
   input  logic [COORD_W-1:0]   pixel_y,
   input  logic [COORD_W-1:0]   swarm_x,
   input  logic [COORD_W-1:0]   swarm_y,
   input  logic [ROWS*COLS-1:0] alive,
   output logic [COORD_W-1:0]   offset_x,
   output logic [COORD_W-1:0]   offset_y,
   output logic                 inside_rect,
   output logic [IDX_W-1:0]     row_d,
   output logic [IDX_W-1:0]     col_d,
   output logic                 valid_d
);

   localparam int SHIFT_X = pitch_shift(PITCH_X);
   localparam int SHIFT_Y = pitch_shift(PITCH_Y);

   logic [REL_W-1:0]     rel_x_s;
   logic [REL_W-1:0]     rel_y_s;
   logic [COORD_W-1:0]   col_full_s;
   logic [COORD_W-1:0]   row_full_s;
   logic [COORD_W-1:0]   off_x_s;
   logic [COORD_W-1:0]   off_y_s;
   logic [IDX_W-1:0]     col_s;
   logic [IDX_W-1:0]     row_s;
   logic [ROWS*COLS-1:0] cell_sel_s;
   logic                 inside_s;
   logic [IDX_W-1:0]     row_r;
   logic [IDX_W-1:0]     col_r;

   // A borrow out of the 12-bit subtraction lands in the MSB.
   assign rel_x_s    = {1'b0, pixel_x} - {1'b0, swarm_x};
   assign rel_y_s    = {1'b0, pixel_y} - {1'b0, swarm_y};
   assign col_full_s = rel_x_s[COORD_W-1:0] >> SHIFT_X;
   assign row_full_s = rel_y_s[COORD_W-1:0] >> SHIFT_Y;
   assign off_x_s    = rel_x_s[COORD_W-1:0] & COORD_W'(PITCH_X - 1);
   assign off_y_s    = rel_y_s[COORD_W-1:0] & COORD_W'(PITCH_Y - 1);
   assign col_s      = col_full_s[IDX_W-1:0];
   assign row_s      = row_full_s[IDX_W-1:0];

   // Select the addressed cell and decide whether the pixel is on a live alien.
   always_comb begin
      cell_sel_s = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            cell_sel_s[r*COLS + c] = (row_s == IDX_W'(r)) && (col_s == IDX_W'(c));
         end
      end
      inside_s = !rel_x_s[REL_W-1] && !rel_y_s[REL_W-1] &&
                 (col_full_s < COORD_W'(COLS)) && (row_full_s < COORD_W'(ROWS)) &&
                 (off_x_s < COORD_W'(ALIEN_W)) && (off_y_s < COORD_W'(ALIEN_H)) &&
                 (|(cell_sel_s & alive)) && !blank;
   end

   // Register the decode, then delay cell and valid one more cycle for hits.
   always_ff @(posedge clk) begin
      if (clear) begin
         offset_x    <= '0;
         offset_y    <= '0;
         inside_rect <= 1'b0;
         row_r       <= '0;
         col_r       <= '0;
         row_d       <= '0;
         col_d       <= '0;
         valid_d     <= 1'b0;
      end else begin
         offset_x    <= off_x_s;
         offset_y    <= off_y_s;
         inside_rect <= inside_s;
         row_r       <= row_s;
         col_r       <= col_s;
         row_d       <= row_r;
         col_d       <= col_r;
         valid_d     <= inside_rect;
      end
   end

endmodule

// File: rtl/alien_swarm_ctrl.sv
// Alien formation controller: pixel decode, alive mask, frame-paced march,
// edge drop/reverse, landing and cleared detection.
module alien_swarm_ctrl
   import alien_swarm_pkg::*;
#(
   parameter int COLS        = 8,
   parameter int ROWS        = 4,
   parameter int PITCH_X     = 64,
   parameter int PITCH_Y     = 64,
   parameter int ALIEN_W     = 52,
   parameter int ALIEN_H     = 40,
   parameter int START_X     = 32,
   parameter int START_Y     = 48,
   parameter int LEFT_BOUND  = 0,
   parameter int RIGHT_BOUND = 639,
   parameter int BOTTOM_LINE = 440,
   parameter int STEP_X      = 4,
   parameter int DROP_Y      = 16,
   parameter int STEP_FRAMES = 30
) (
   input  logic         clk,
   input  logic         reset,
   alien_swarm_if.slave bus
);

   localparam int NUM_ALIENS = ROWS * COLS;
   localparam int SHIFT_X    = pitch_shift(PITCH_X);
   localparam int SHIFT_Y    = pitch_shift(PITCH_Y);

   localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(NUM_ALIENS);
   localparam logic [CNT_W-1:0] QUARTER     = CNT_W'(NUM_ALIENS / 4);
   localparam logic [CNT_W-1:0] PERIOD_FULL = CNT_W'(STEP_FRAMES);
   localparam logic [CNT_W-1:0] PERIOD_HALF = CNT_W'(STEP_FRAMES / 2);

   logic                  clear_s;
   logic [NUM_ALIENS-1:0] alive_r;
   logic [CNT_W-1:0]      alive_cnt_r;
   logic [COORD_W-1:0]    swarm_x_r;
   logic [COORD_W-1:0]    swarm_y_r;
   dir_t                  dir_r;
   swarm_state_t          state_r;
   logic [CNT_W-1:0]      frame_cnt_r;
   logic                  landed_r;
   logic                  all_dead_r;

   logic [COORD_W-1:0]    off_x_s;
   logic [COORD_W-1:0]    off_y_s;
   logic                  inside_s;
   logic [IDX_W-1:0]      row_d_s;
   logic [IDX_W-1:0]      col_d_s;
   logic                  valid_d_s;

   logic [NUM_ALIENS-1:0] hit_sel_s;
   logic                  hit_ok_s;
   logic [COLS-1:0]       col_alive_s;
   logic [ROWS-1:0]       row_alive_s;
   logic [COORD_W-1:0]    min_col_s;
   logic [COORD_W-1:0]    max_col_s;
   logic [COORD_W-1:0]    max_row_s;
   logic [REL_W-1:0]      left_px_s;
   logic [REL_W-1:0]      right_px_s;
   logic [REL_W-1:0]      bottom_px_s;
   logic                  fits_left_s;
   logic                  fits_right_s;
   logic                  lands_s;
   logic [CNT_W-1:0]      period_s;
   logic                  step_s;

   swarm_state_t          state_s;
   logic [COORD_W-1:0]    x_s;
   logic [COORD_W-1:0]    y_s;
   dir_t                  dir_s;

   // Restart behaves exactly like reset.
   assign clear_s = reset | bus.restart;

   alien_grid_decode #(
      .COLS    (COLS),
      .ROWS    (ROWS),
      .PITCH_X (PITCH_X),
      .PITCH_Y (PITCH_Y),
      .ALIEN_W (ALIEN_W),
      .ALIEN_H (ALIEN_H)
   ) u_decode (
      .clk         (clk),
      .clear       (clear_s),
      .blank       (state_r == CLEARED),
      .pixel_x     (bus.pixelX),
      .pixel_y     (bus.pixelY),
      .swarm_x     (swarm_x_r),
      .swarm_y     (swarm_y_r),
      .alive       (alive_r),
      .offset_x    (off_x_s),
      .offset_y    (off_y_s),
      .inside_rect (inside_s),
      .row_d       (row_d_s),
      .col_d       (col_d_s),
      .valid_d     (valid_d_s)
   );

   assign bus.offsetX         = off_x_s;
   assign bus.offsetY         = off_y_s;
   assign bus.InsideRectangle = inside_s;
   assign bus.swarmX          = swarm_x_r;
   assign bus.swarmY          = swarm_y_r;
   assign bus.aliveCount      = alive_cnt_r;
   assign bus.allDead         = all_dead_r;
   assign bus.landed          = landed_r;

   // One-hot of the delayed hit cell; a hit counts only on a live alien.
   always_comb begin
      hit_sel_s = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            hit_sel_s[r*COLS + c] = (row_d_s == IDX_W'(r)) && (col_d_s == IDX_W'(c));
         end
      end
      hit_ok_s = bus.alienHit && valid_d_s && (|(hit_sel_s & alive_r));
   end

   // Alive mask and live-alien count.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         alive_r     <= '1;
         alive_cnt_r <= FULL_COUNT;
      end else if (hit_ok_s) begin
         alive_r     <= alive_r & ~hit_sel_s;
         alive_cnt_r <= alive_cnt_r - CNT_W'(1);
      end else begin
         alive_r     <= alive_r;
         alive_cnt_r <= alive_cnt_r;
      end
   end

   // Live extents of the formation, taken from the current (pre-hit) mask.
   always_comb begin
      col_alive_s = '0;
      row_alive_s = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            col_alive_s[c] = col_alive_s[c] | alive_r[r*COLS + c];
            row_alive_s[r] = row_alive_s[r] | alive_r[r*COLS + c];
         end
      end
      min_col_s = '0;
      max_col_s = '0;
      max_row_s = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         min_col_s = col_alive_s[c] ? COORD_W'(c) : min_col_s;
      end
      for (int c = 0; c < COLS; c++) begin
         max_col_s = col_alive_s[c] ? COORD_W'(c) : max_col_s;
      end
      for (int r = 0; r < ROWS; r++) begin
         max_row_s = row_alive_s[r] ? COORD_W'(r) : max_row_s;
      end
      left_px_s    = REL_W'(swarm_x_r) + (REL_W'(min_col_s) << SHIFT_X);
      right_px_s   = REL_W'(swarm_x_r) + (REL_W'(max_col_s) << SHIFT_X) + REL_W'(ALIEN_W - 1);
      bottom_px_s  = REL_W'(swarm_y_r) + (REL_W'(max_row_s) << SHIFT_Y) + REL_W'(ALIEN_H - 1);
      // Left check compares against LEFT_BOUND + STEP_X so nothing underflows.
      fits_left_s  = !(left_px_s < REL_W'(LEFT_BOUND + STEP_X));
      fits_right_s = (right_px_s + REL_W'(STEP_X)) <= REL_W'(RIGHT_BOUND);
      lands_s      = (bottom_px_s + REL_W'(DROP_Y)) >= REL_W'(BOTTOM_LINE);
   end

   // Step period speeds up as the swarm thins out; step fires on startOfFrame.
   always_comb begin
      if (alive_cnt_r > QUARTER) begin
         period_s = PERIOD_FULL;
      end else if (alive_cnt_r > CNT_W'(1)) begin
         period_s = PERIOD_HALF;
      end else begin
         period_s = CNT_W'(1);
      end
      step_s = bus.startOfFrame && (frame_cnt_r >= (period_s - CNT_W'(1)));
   end

   // Frame counter: counts startOfFrame pulses, clears when a step fires.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         frame_cnt_r <= '0;
      end else if (step_s) begin
         frame_cnt_r <= '0;
      end else if (bus.startOfFrame) begin
         frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   // Next state and next position; position only moves on startOfFrame.
   always_comb begin
      state_s = state_r;
      x_s     = swarm_x_r;
      y_s     = swarm_y_r;
      dir_s   = dir_r;
      case (state_r)
         MARCH: begin
            if (step_s) begin
               if (dir_r == DIR_RIGHT) begin
                  if (fits_right_s) begin
                     x_s = swarm_x_r + COORD_W'(STEP_X);
                  end else begin
                     state_s = DROP;
                  end
               end else begin
                  if (fits_left_s) begin
                     x_s = swarm_x_r - COORD_W'(STEP_X);
                  end else begin
                     state_s = DROP;
                  end
               end
            end else begin
               state_s = MARCH;
            end
         end
         DROP: begin
            if (bus.startOfFrame) begin
               y_s     = swarm_y_r + COORD_W'(DROP_Y);
               dir_s   = (dir_r == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
               state_s = lands_s ? LANDED : MARCH;
            end else begin
               state_s = DROP;
            end
         end
         LANDED:  state_s = LANDED;
         CLEARED: state_s = CLEARED;
         default: state_s = MARCH;
      endcase
      // An empty swarm overrides everything, including a landing.
      if (alive_cnt_r == CNT_W'(0)) begin
         state_s = CLEARED;
         x_s     = swarm_x_r;
         y_s     = swarm_y_r;
         dir_s   = dir_r;
      end else begin
         state_s = state_s;
      end
   end

   // State, position and status flag registers.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         state_r    <= MARCH;
         swarm_x_r  <= COORD_W'(START_X);
         swarm_y_r  <= COORD_W'(START_Y);
         dir_r      <= DIR_RIGHT;
         landed_r   <= 1'b0;
         all_dead_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         swarm_x_r  <= x_s;
         swarm_y_r  <= y_s;
         dir_r      <= dir_s;
         landed_r   <= (state_s == LANDED);
         all_dead_r <= (state_s == CLEARED);
      end
   end

endmodule

// File: tb/tb_alien_swarm_ctrl.sv
// Directed bench for alien_swarm_ctrl with hand-computed expectations.
module tb_alien_swarm_ctrl;
   import alien_swarm_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;
   int   exp_x;
   int   exp_y;
   int   guard;

   alien_swarm_if bus ();

   alien_swarm_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic probe(input int x, input int y);
      bus.pixelX = 11'(x);
      bus.pixelY = 11'(y);
      tick();
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         bus.startOfFrame = 1'b1;
         tick();
         bus.startOfFrame = 1'b0;
         tick();
      end
   endtask

   task automatic kill(input int r, input int c);
      bus.pixelX = 11'(exp_x + c * 64);
      bus.pixelY = 11'(exp_y + r * 64);
      tick(2);
      bus.alienHit = 1'b1;
      tick();
      bus.alienHit = 1'b0;
   endtask

   task automatic do_restart();
      bus.restart = 1'b1;
      tick();
      bus.restart = 1'b0;
      exp_x = 32;
      exp_y = 48;
   endtask

   initial begin
      reset            = 1'b1;
      bus.startOfFrame = 1'b0;
      bus.restart      = 1'b0;
      bus.alienHit     = 1'b0;
      bus.pixelX       = 11'd32;
      bus.pixelY       = 11'd48;
      exp_x            = 32;
      exp_y            = 48;
      tick(2);
      chk("rst_inside", 32'(bus.InsideRectangle), 32'd0);
      chk("rst_offx", 32'(bus.offsetX), 32'd0);
      chk("rst_count", 32'(bus.aliveCount), 32'd32);
      chk("rst_swarmx", 32'(bus.swarmX), 32'd32);
      chk("rst_swarmy", 32'(bus.swarmY), 32'd48);
      chk("rst_landed", 32'(bus.landed), 32'd0);
      chk("rst_alldead", 32'(bus.allDead), 32'd0);
      reset = 1'b0;
      tick();
      chk("tl_inside", 32'(bus.InsideRectangle), 32'd1);
      chk("tl_offx", 32'(bus.offsetX), 32'd0);
      chk("tl_offy", 32'(bus.offsetY), 32'd0);

      // Cell geometry boundaries.
      probe(83, 87);
      chk("br_inside", 32'(bus.InsideRectangle), 32'd1);
      chk("br_offx", 32'(bus.offsetX), 32'd51);
      chk("br_offy", 32'(bus.offsetY), 32'd39);
      probe(84, 48);
      chk("gapx_inside", 32'(bus.InsideRectangle), 32'd0);
      chk("gapx_offx", 32'(bus.offsetX), 32'd52);
      probe(31, 48);
      chk("borrow_inside", 32'(bus.InsideRectangle), 32'd0);
      probe(32, 88);
      chk("gapy_inside", 32'(bus.InsideRectangle), 32'd0);
      probe(480, 240);
      chk("last_cell_inside", 32'(bus.InsideRectangle), 32'd1);
      probe(544, 48);
      chk("col_oob_inside", 32'(bus.InsideRectangle), 32'd0);
      probe(32, 304);
      chk("row_oob_inside", 32'(bus.InsideRectangle), 32'd0);

      // Hits.
      kill(0, 1);
      chk("hit01_count", 32'(bus.aliveCount), 32'd31);
      probe(96, 48);
      chk("dead01_inside", 32'(bus.InsideRectangle), 32'd0);
      probe(160, 48);
      chk("live02_inside", 32'(bus.InsideRectangle), 32'd1);
      kill(0, 1);
      chk("rehit_count", 32'(bus.aliveCount), 32'd31);
      bus.pixelX = 11'd84;
      bus.pixelY = 11'd48;
      tick(2);
      bus.alienHit = 1'b1;
      tick();
      bus.alienHit = 1'b0;
      chk("gap_hit_count", 32'(bus.aliveCount), 32'd31);

      // March right, drop at x=140, march back left.
      frames(30);
      chk("step1_x", 32'(bus.swarmX), 32'd36);
      chk("step1_y", 32'(bus.swarmY), 32'd48);
      frames(780);
      chk("edge_x", 32'(bus.swarmX), 32'd140);
      frames(30);
      chk("dropfire_x", 32'(bus.swarmX), 32'd140);
      chk("dropfire_y", 32'(bus.swarmY), 32'd48);
      frames(1);
      chk("dropped_y", 32'(bus.swarmY), 32'd64);
      chk("dropped_x", 32'(bus.swarmX), 32'd140);
      frames(28);
      chk("pre_left_x", 32'(bus.swarmX), 32'd140);
      frames(1);
      chk("left_x", 32'(bus.swarmX), 32'd136);

      // Restart coinciding with a hit: restart wins.
      bus.pixelX = 11'd136;
      bus.pixelY = 11'd64;
      tick(2);
      bus.alienHit = 1'b1;
      bus.restart  = 1'b1;
      tick();
      bus.alienHit = 1'b0;
      bus.restart  = 1'b0;
      exp_x = 32;
      exp_y = 48;
      chk("rs_hit_count", 32'(bus.aliveCount), 32'd32);
      chk("rs_x", 32'(bus.swarmX), 32'd32);
      chk("rs_y", 32'(bus.swarmY), 32'd48);
      chk("rs_inside", 32'(bus.InsideRectangle), 32'd0);

      // Narrower formation (columns 4..7 gone) marches further right.
      for (int r = 0; r < 4; r++) begin
         for (int c = 4; c < 8; c++) begin
            kill(r, c);
         end
      end
      chk("half_count", 32'(bus.aliveCount), 32'd16);
      frames(2730);
      chk("narrow_edge_x", 32'(bus.swarmX), 32'd396);
      frames(30);
      chk("narrow_dropfire_y", 32'(bus.swarmY), 32'd48);
      chk("narrow_dropfire_x", 32'(bus.swarmX), 32'd396);
      frames(1);
      chk("narrow_dropped_y", 32'(bus.swarmY), 32'd64);

      // Speed-up: 8 alive -> 15 frames, 1 alive -> every frame; then cleared.
      do_restart();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 8; c++) begin
            kill(r, c);
         end
      end
      chk("eight_count", 32'(bus.aliveCount), 32'd8);
      frames(14);
      chk("p15_hold_x", 32'(bus.swarmX), 32'd32);
      frames(1);
      chk("p15_step_x", 32'(bus.swarmX), 32'd36);
      exp_x = 36;
      for (int c = 0; c < 7; c++) begin
         kill(3, c);
      end
      chk("one_count", 32'(bus.aliveCount), 32'd1);
      frames(1);
      chk("p1_step_x", 32'(bus.swarmX), 32'd40);
      frames(1);
      chk("p1_step2_x", 32'(bus.swarmX), 32'd44);
      exp_x = 44;
      kill(3, 7);
      chk("zero_count", 32'(bus.aliveCount), 32'd0);
      tick();
      chk("all_dead", 32'(bus.allDead), 32'd1);
      probe(492, 240);
      chk("cleared_inside", 32'(bus.InsideRectangle), 32'd0);
      frames(5);
      chk("cleared_frozen_x", 32'(bus.swarmX), 32'd44);

      // Full swarm drops repeatedly until it lands at y=224, x=140.
      do_restart();
      chk("rs2_count", 32'(bus.aliveCount), 32'd32);
      chk("rs2_alldead", 32'(bus.allDead), 32'd0);
      guard = 0;
      while (bus.landed !== 1'b1 && guard < 15000) begin
         frames(1);
         guard++;
      end
      chk("landed", 32'(bus.landed), 32'd1);
      chk("landed_x", 32'(bus.swarmX), 32'd140);
      chk("landed_y", 32'(bus.swarmY), 32'd224);
      frames(60);
      chk("frozen_x", 32'(bus.swarmX), 32'd140);
      chk("frozen_y", 32'(bus.swarmY), 32'd224);
      chk("still_landed", 32'(bus.landed), 32'd1);
      exp_x = 140;
      exp_y = 224;
      kill(0, 0);
      chk("landed_hit_count", 32'(bus.aliveCount), 32'd31);
      do_restart();
      chk("rs3_landed", 32'(bus.landed), 32'd0);
      chk("rs3_x", 32'(bus.swarmX), 32'd32);
      chk("rs3_y", 32'(bus.swarmY), 32'd48);
      chk("rs3_count", 32'(bus.aliveCount), 32'd32);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
